// File: rtl/goto_rep_pkg.sv
// Shared types for the goto-repetition monitor: FSM states and failure causes.
package goto_rep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_COUNT   = 2'd2,
    ST_CHECK_C = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE         = 2'd0,
    FC_MAX_EXCEEDED = 2'd1,
    FC_TIMEOUT      = 2'd2
  } fail_code_e;

endpackage

// File: rtl/goto_rep_monitor_if.sv
// Event inputs and verdict/statistics outputs of the goto-repetition monitor.
interface goto_rep_monitor_if
  import goto_rep_pkg::*;
#(
  parameter int unsigned MAX_B = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned BC_W = $clog2(MAX_B + 1);

  logic             a;
  logic             b;
  logic             c;
  logic             busy;
  logic             pass;
  logic             fail;
  fail_code_e       fail_code;
  logic [BC_W-1:0]  b_count;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             drop;

  modport master (
    output a, b, c,
    input  busy, pass, fail, fail_code, b_count, pass_cnt, fail_cnt, drop
  );

  modport slave (
    input  a, b, c,
    output busy, pass, fail, fail_code, b_count, pass_cnt, fail_cnt, drop
  );
endinterface

// File: rtl/goto_rep_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  // Count up on inc, never wrapping past all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/goto_rep_monitor.sv
// Checks a ##1 b[->MIN_B:MAX_B] ##0/##1 c style sequence after each rise of a,
// with a timeout, drop reporting and saturating pass/fail totals.
module goto_rep_monitor
  import goto_rep_pkg::*;
#(
  parameter int unsigned MIN_B   = 2,
  parameter int unsigned MAX_B   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input logic               clk,
  input logic               rst_n,
  goto_rep_monitor_if.slave bus
);

  localparam int unsigned BC_W  = $clog2(MAX_B + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [BC_W-1:0]  MIN_BC   = BC_W'(MIN_B);
  localparam logic [BC_W-1:0]  MAX_BC   = BC_W'(MAX_B);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  if ((MIN_B < 1) || (MAX_B < MIN_B)) begin : g_bad_params
    $error("goto_rep_monitor: parameters must satisfy 1 <= MIN_B <= MAX_B");
  end

  state_e          state;
  logic            a_q;
  logic            busy_q;
  logic            pass_q;
  logic            fail_q;
  logic            drop_q;
  fail_code_e      fc_q;
  logic [BC_W-1:0] bc_q;
  logic [TMO_W-1:0] tmo_q;

  logic            rise;
  logic            pass_set;
  logic            max_set;
  logic            tmo_set;
  logic            fail_set;
  logic [BC_W-1:0] bc_inc;

  assign rise   = bus.a & ~a_q;
  assign bc_inc = bc_q + BC_W'(1);

  // Verdict of the current cycle: pass beats max-exceeded beats timeout.
  always_comb begin
    pass_set = 1'b0;
    max_set  = 1'b0;
    tmo_set  = 1'b0;
    if (state == ST_CHECK_C) begin
      pass_set = bus.c;
      max_set  = !bus.c && (bc_q == MAX_BC);
    end
    if ((state != ST_IDLE) && (tmo_q == TMO_LAST) && !pass_set && !max_set) begin
      tmo_set = 1'b1;
    end
    fail_set = max_set | tmo_set;
  end

  // Sequence FSM with registered verdict, busy and drop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= 1'b0;
      busy_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      drop_q <= 1'b0;
      fc_q   <= FC_NONE;
      bc_q   <= '0;
      tmo_q  <= '0;
    end else begin
      a_q    <= bus.a;
      pass_q <= pass_set;
      fail_q <= fail_set;
      // Any rise while an attempt is open is discarded, including on the verdict cycle.
      drop_q <= rise && (state != ST_IDLE);
      if (state != ST_IDLE) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
      if (fail_set) begin
        fc_q <= max_set ? FC_MAX_EXCEEDED : FC_TIMEOUT;
      end
      if (pass_set || fail_set) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state  <= ST_DELAY;
              busy_q <= 1'b1;
              bc_q   <= '0;
              tmo_q  <= '0;
            end
          end
          ST_DELAY: begin
            state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (bus.b) begin
              bc_q <= bc_inc;
              if (bc_inc >= MIN_BC) begin
                state <= ST_CHECK_C;
              end
            end
          end
          ST_CHECK_C: begin
            if (bus.b) begin
              bc_q <= bc_inc;
            end else begin
              state <= ST_COUNT;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Running totals of verdicts; counted on the same edge the pulse appears.
  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pass_set),
    .clear (1'b0),
    .count (bus.pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_set),
    .clear (1'b0),
    .count (bus.fail_cnt)
  );

  assign bus.busy      = busy_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.drop      = drop_q;
  assign bus.fail_code = fc_q;
  assign bus.b_count   = bc_q;

endmodule

// File: tb/tb_goto_rep_monitor.sv
// Directed bench for goto_rep_monitor (MIN_B=2, MAX_B=4, TIMEOUT=64).
module tb_goto_rep_monitor;
  import goto_rep_pkg::*;

  logic clk;
  logic rst_n;
  logic a, b, c;

  int n_chk;
  int n_fail;

  goto_rep_monitor_if #(.MAX_B(4), .CNT_W(16)) bus ();
  goto_rep_monitor_if #(.MAX_B(4), .CNT_W(2))  bus2 ();

  assign bus.a  = a;
  assign bus.b  = b;
  assign bus.c  = c;
  assign bus2.a = a;
  assign bus2.b = b;
  assign bus2.c = c;

  goto_rep_monitor #(.MIN_B(2), .MAX_B(4), .TIMEOUT(64), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Narrow-counter copy used to reach fail_cnt saturation quickly.
  goto_rep_monitor #(.MIN_B(2), .MAX_B(4), .TIMEOUT(64), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  abc;   // a, b, c
    logic [3:0]  flags; // busy, pass, fail, drop
    logic [2:0]  bc;
    logic [1:0]  fc;
    logic [15:0] pc;
    logic [15:0] fcn;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [2:0] abc, input logic [3:0] flags,
                              input logic [2:0] bc, input logic [1:0] fc,
                              input logic [15:0] pc, input logic [15:0] fcn);
    vec_t v;
    v.abc = abc; v.flags = flags; v.bc = bc; v.fc = fc; v.pc = pc; v.fcn = fcn;
    tbl.push_back(v);
  endfunction

  function automatic logic [40:0] obs();
    return {bus.busy, bus.pass, bus.fail, bus.drop, bus.b_count,
            2'(bus.fail_code), bus.pass_cnt, bus.fail_cnt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] abc);
    {a, b, c} = abc;
    @(posedge clk);
    #1;
  endtask

  // One attempt ending in a max-exceeded failure.
  task automatic max_fail();
    step(3'b100);
    chk("mf_rise_busy", 64'(bus.busy), 64'd1);
    step(3'b000);
    for (int k = 0; k < 4; k++) step(3'b010);
    step(3'b000);
    chk("mf_fail", {62'd0, bus.fail, bus.pass}, 64'b10);
  endtask

  initial begin
    int bad;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    {a, b, c} = 3'b000;

    // abc, busy/pass/fail/drop, bc, fc, pass_cnt, fail_cnt
    // Pass with b at 2 and 4, c at 5; first edge after reset sees a as a rise.
    add(3'b100, 4'b1000, 3'd0, 2'd0, 16'd0, 16'd0);
    add(3'b100, 4'b1000, 3'd0, 2'd0, 16'd0, 16'd0);
    add(3'b010, 4'b1000, 3'd1, 2'd0, 16'd0, 16'd0);
    add(3'b000, 4'b1000, 3'd1, 2'd0, 16'd0, 16'd0);
    add(3'b010, 4'b1000, 3'd2, 2'd0, 16'd0, 16'd0);
    add(3'b001, 4'b0100, 3'd2, 2'd0, 16'd1, 16'd0);
    add(3'b000, 4'b0000, 3'd2, 2'd0, 16'd1, 16'd0);
    // Max exceeded with a re-rise at edge 3 dropped.
    add(3'b100, 4'b1000, 3'd0, 2'd0, 16'd1, 16'd0);
    add(3'b000, 4'b1000, 3'd0, 2'd0, 16'd1, 16'd0);
    add(3'b010, 4'b1000, 3'd1, 2'd0, 16'd1, 16'd0);
    add(3'b110, 4'b1001, 3'd2, 2'd0, 16'd1, 16'd0);
    add(3'b110, 4'b1000, 3'd3, 2'd0, 16'd1, 16'd0);
    add(3'b010, 4'b1000, 3'd4, 2'd0, 16'd1, 16'd0);
    add(3'b000, 4'b0010, 3'd4, 2'd1, 16'd1, 16'd1);
    add(3'b000, 4'b0000, 3'd4, 2'd1, 16'd1, 16'd1);
    // c beats b in CHECK_C; a rise on the verdict cycle is dropped.
    add(3'b100, 4'b1000, 3'd0, 2'd1, 16'd1, 16'd1);
    add(3'b000, 4'b1000, 3'd0, 2'd1, 16'd1, 16'd1);
    add(3'b010, 4'b1000, 3'd1, 2'd1, 16'd1, 16'd1);
    add(3'b010, 4'b1000, 3'd2, 2'd1, 16'd1, 16'd1);
    add(3'b111, 4'b0101, 3'd2, 2'd1, 16'd2, 16'd1);
    add(3'b100, 4'b0000, 3'd2, 2'd1, 16'd2, 16'd1);
    add(3'b000, 4'b0000, 3'd2, 2'd1, 16'd2, 16'd1);
    // CHECK_C falls back to COUNT, where c is ignored.
    add(3'b100, 4'b1000, 3'd0, 2'd1, 16'd2, 16'd1);
    add(3'b000, 4'b1000, 3'd0, 2'd1, 16'd2, 16'd1);
    add(3'b010, 4'b1000, 3'd1, 2'd1, 16'd2, 16'd1);
    add(3'b010, 4'b1000, 3'd2, 2'd1, 16'd2, 16'd1);
    add(3'b000, 4'b1000, 3'd2, 2'd1, 16'd2, 16'd1);
    add(3'b001, 4'b1000, 3'd2, 2'd1, 16'd2, 16'd1);
    add(3'b010, 4'b1000, 3'd3, 2'd1, 16'd2, 16'd1);
    add(3'b001, 4'b0100, 3'd3, 2'd1, 16'd3, 16'd1);
    add(3'b000, 4'b0000, 3'd3, 2'd1, 16'd3, 16'd1);

    #12;
    chk("reset_state", 64'(obs()), 64'd0);
    chk("reset_dut2_fail_cnt", 64'(bus2.fail_cnt), 64'd0);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      logic [40:0] exp;
      step(tbl[i].abc);
      exp = {tbl[i].flags, tbl[i].bc, tbl[i].fc, tbl[i].pc, tbl[i].fcn};
      chk($sformatf("vec%0d", i), 64'(obs()), 64'(exp));
    end

    // Timeout: b at edge 1 ignored, one b counted, c in COUNT ignored.
    step(3'b100);
    step(3'b010);
    step(3'b000);
    step(3'b010);
    step(3'b001);
    chk("tmo_edge4", {61'd0, bus.busy, bus.pass, bus.b_count == 3'd1}, 64'b101);
    bad = 0;
    for (int e = 5; e <= 63; e++) begin
      step(3'b000);
      if (bus.pass || bus.fail || !bus.busy) bad++;
    end
    chk("tmo_quiet_until_63", 64'(bad), 64'd0);
    step(3'b000);
    chk("tmo_fail_edge64", {58'd0, bus.busy, bus.pass, bus.fail, 2'(bus.fail_code), 1'b0},
        {58'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0});
    chk("tmo_fail_cnt", 64'(bus.fail_cnt), 64'd2);

    // Reset while in CHECK_C with c asserted.
    step(3'b100);
    step(3'b000);
    step(3'b010);
    step(3'b010);
    chk("pre_reset_busy", {62'd0, bus.busy, bus.b_count == 3'd2}, 64'b11);
    {a, b, c} = 3'b001;
    rst_n = 1'b0;
    #2;
    chk("async_reset_clear", 64'(obs()), 64'd0);
    @(posedge clk);
    #1;
    chk("reset_no_pulse", {62'd0, bus.pass, bus.fail}, 64'd0);
    #3;
    rst_n = 1'b1;
    c = 1'b0;

    // fail_cnt saturation on the 2-bit copy.
    for (int k = 0; k < 3; k++) max_fail();
    chk("sat_dut2_all_ones", 64'(bus2.fail_cnt), 64'd3);
    chk("sat_main_cnt3", 64'(bus.fail_cnt), 64'd3);
    max_fail();
    chk("sat_dut2_holds", 64'(bus2.fail_cnt), 64'd3);
    chk("sat_main_cnt4", 64'(bus.fail_cnt), 64'd4);
    chk("sat_fail_code", 64'(bus.fail_code), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/goto_rep_monitor.md
GOTO_REP_MONITOR -- requirements
Module: goto_rep_monitor

Interface
REQ-001 The block SHALL have parameter MIN_B, default 2, meaning minimum b occurrences before c may complete the sequence (>=1).
REQ-002 The block SHALL have parameter MAX_B, default 4, meaning maximum b occurrences; MAX_B >= MIN_B, elaboration error otherwise.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning maximum cycles from trigger to verdict.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning width of the pass and fail counters.
REQ-005 The block SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports: a  in  1  trigger; b  in  1  counted event; c  in  1  completion event.
REQ-007 The block SHALL have ports: busy  out  1  attempt in flight; pass  out  1  one-cycle pass pulse; fail  out  1  one-cycle fail pulse.
REQ-008 The block SHALL have ports: fail_code  out  2  cause, valid with fail; b_count  out  $clog2(MAX_B+1)  b occurrences in current attempt.
REQ-009 The block SHALL have ports: pass_cnt, fail_cnt  out  CNT_W  saturating totals; drop  out  1  one-cycle pulse for a trigger ignored while busy.

Function
REQ-010 The block SHALL sample all inputs on rising clk and detect rise as a=1 with registered a_q=0; a_q SHALL reset to 0.
REQ-011 The block SHALL implement FSM states IDLE, DELAY, COUNT, CHECK_C.
REQ-012 The block SHALL move IDLE->DELAY at the edge where a rise is detected (edge t), clearing b_count and the timeout counter.
REQ-013 The block SHALL move DELAY->COUNT unconditionally (edge t+1); b is ignored at t+1, so the first countable b is at edge t+2.
REQ-014 In COUNT with b=1, the block SHALL increment b_count and move to CHECK_C if the new count >= MIN_B, else stay in COUNT.
REQ-015 In CHECK_C with c=1, the block SHALL pulse pass the same cycle the state returns to IDLE; c has priority over b.
REQ-016 In CHECK_C with c=0 and b_count==MAX_B, the block SHALL pulse fail with fail_code=MAX_EXCEEDED and return to IDLE.
REQ-017 In CHECK_C with c=0, b_count<MAX_B and b=1, the block SHALL increment b_count and stay in CHECK_C.
REQ-018 In CHECK_C with c=0, b_count<MAX_B and b=0, the block SHALL return to COUNT.
REQ-019 c in COUNT SHALL be ignored.
REQ-020 The timeout counter SHALL increment each busy cycle.
REQ-021 On reaching TIMEOUT without pass, the block SHALL pulse fail with fail_code=TIMEOUT and return to IDLE; pass wins over timeout, and MAX_EXCEEDED wins over TIMEOUT, in the same cycle.
REQ-022 A rise detected while busy (DELAY/COUNT/CHECK_C) SHALL pulse drop and not restart the attempt.
REQ-023 A rise in the same cycle as a verdict SHALL also be dropped, and IDLE SHALL be entered.
REQ-024 busy SHALL be 1 in DELAY, COUNT and CHECK_C.
REQ-025 pass and fail SHALL be registered, mutually exclusive, one cycle wide.
REQ-026 fail_code SHALL be NONE=0, MAX_EXCEEDED=1, TIMEOUT=2, and SHALL hold its last value until the next fail.
REQ-027 pass_cnt and fail_cnt SHALL increment on the corresponding pulse and saturate at all-ones without wrap.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, a_q=0, busy=0, pass=0, fail=0, drop=0, fail_code=NONE, b_count=0, timeout counter=0, pass_cnt=0, fail_cnt=0.
REQ-029 Reset asserted mid-attempt SHALL abandon the attempt with no pass or fail pulse.
REQ-030 The first edge after deassertion SHALL treat a=1 as a rise.

Structure
REQ-031 Package goto_rep_pkg SHALL hold the state enum and the fail_code enum (2 bits).
REQ-032 Sub-module sat_counter (parameter W; inputs inc and clear; output count) SHALL implement pass_cnt and fail_cnt.

Verification (MIN_B=2, MAX_B=4, TIMEOUT=64)
REQ-033 Stimulus: a rises at edge 0; b at edges 2 and 4; c at 5 -> required response: pass at edge 5, b_count=2, pass_cnt=1.
REQ-034 Stimulus: rise; b at edges 2, 3, 4, 5; c=0 at 6 -> required response: fail at 6, fail_code=1.
REQ-035 Stimulus: rise; b at edge 1 only, then b at 3, c at 4 -> required response: the edge-1 b is ignored, b_count=1 at edge 4, no pass; timeout fail at edge 64, fail_code=2.
REQ-036 Stimulus: rise at edge 0; a falls and rises again at edge 3 -> required response: drop pulse at 3, attempt continues unchanged.
REQ-037 Stimulus: rst_n low while in CHECK_C -> required response: all outputs zero immediately, no pulse.
REQ-038 Stimulus: force fail_cnt to all-ones, then one further fail -> required response: fail_cnt holds all-ones.
